parity_lane_pipe: RTL

- Multi-lane, registered parity generator/checker on a valid/ready stream.
- Splits each data word into LANES lanes of WIDTH bits.
- Per lane, either generates a parity bit (even or odd) or checks a received parity bit, and flags an error.
- Sits between a data source and a link/storage stage; keeps a saturating count of errored beats for status readout.

---
 rtl/parity_lane_pipe_pkg.sv | 10 +
 rtl/parity_lane_calc.sv | 32 +++
 rtl/parity_lane_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/parity_lane_pipe_pkg.sv
// Shared constants for the parity lane pipeline: parity sense and operating mode encodings.
package parity_lane_pipe_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/parity_lane_calc.sv
// Combinational per-lane parity generator/checker for one WIDTH-bit lane.
module parity_lane_calc
  import parity_lane_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] lane_data,
  input  logic             in_parity,
  input  logic             parity_type,
  input  logic             mode,
  output logic             parity_bit,
  output logic             err
);

  logic red_s;

  assign red_s = ^lane_data;

  // Select generated parity or pass-through received parity, flagging mismatches in check mode
  always_comb begin
    parity_bit = 1'b0;
    err        = 1'b0;
    if (mode == MODE_CHK) begin
      parity_bit = in_parity;
      err        = red_s ^ in_parity ^ parity_type;
    end else begin
      parity_bit = red_s ^ parity_type;
      err        = 1'b0;
    end
  end

endmodule

// File: rtl/parity_lane_pipe.sv
// Registered multi-lane parity generator/checker on a valid/ready stream,
// with a saturating count of errored beats.
module parity_lane_pipe
  import parity_lane_pipe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   parity_type,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_parity,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_parity,
  output logic [LANES-1:0]       out_err,
  output logic [ERR_CNT_W-1:0]   err_count,
  input  logic                   err_count_clr
);

  logic                   out_valid_r;
  logic [LANES*WIDTH-1:0] out_data_r;
  logic [LANES-1:0]       out_parity_r;
  logic [LANES-1:0]       out_err_r;
  logic [ERR_CNT_W-1:0]   err_count_r;

  logic [LANES-1:0]       par_next_s;
  logic [LANES-1:0]       err_next_s;
  logic                   accept_s;
  logic                   cnt_sat_s;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    parity_lane_calc #(.WIDTH(WIDTH)) u_calc (
      .lane_data   (in_data[i*WIDTH +: WIDTH]),
      .in_parity   (in_parity[i]),
      .parity_type (parity_type),
      .mode        (mode),
      .parity_bit  (par_next_s[i]),
      .err         (err_next_s[i])
    );
  end

  // Reset gates in_ready so nothing is accepted while the pipe is being cleared
  assign in_ready  = rst_n & (~out_valid_r | out_ready);
  assign accept_s  = in_valid & in_ready;
  assign cnt_sat_s = (err_count_r == {ERR_CNT_W{1'b1}});

  // Output register and valid flag (EMPTY/FULL)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_parity_r <= '0;
      out_err_r    <= '0;
    end else if (accept_s) begin
      out_valid_r  <= 1'b1;
      out_data_r   <= in_data;
      out_parity_r <= par_next_s;
      out_err_r    <= err_next_s;
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

  // Errored-beat counter; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_r <= '0;
    end else if (err_count_clr) begin
      err_count_r <= '0;
    end else if (accept_s && (mode == MODE_CHK) && (|err_next_s) && !cnt_sat_s) begin
      err_count_r <= err_count_r + ERR_CNT_W'(1);
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_parity = out_parity_r;
  assign out_err    = out_err_r;
  assign err_count  = err_count_r;

endmodule
